// File: rtl/uart_cmd_parser.sv
// Assembles {HEADER, CMD, ARG, CHK} frames from UART receiver bytes and strobes validated Cmd/Arg.
// Optional UART_CMD_ACK_EN adds an ACK/NAK request path toward a UART transmitter.
module uart_cmd_parser #(
  parameter logic [7:0] HEADER         = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter int         CNT_W          = 18
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] RxData,
  input  logic       RxDone,
`ifdef UART_CMD_ACK_EN
  input  logic       TxBusy,
  output logic [7:0] TxData,
  output logic       TxStart,
`endif
  output logic [7:0] Cmd,
  output logic [7:0] Arg,
  output logic       CmdValid,
  output logic       ChkErr,
  output logic       TimeoutErr,
  output logic       Busy,
  output logic [1:0] DbgState
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ARG, S_CHK} state_t;

  // Byte events are rising edges of RxDone. Strobes are registered, so they appear the cycle
  // after the event edge and last exactly one cycle.
  state_t           state, state_next;
  logic             rx_done_q;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       cmd_tmp, cmd_tmp_next, arg_tmp, arg_tmp_next;
  logic [7:0]       cmd_next, arg_next;
  logic             valid_next, chk_next, to_next;
  logic             byte_event, timeout_hit;

  assign byte_event  = RxDone & ~rx_done_q;
  // A byte on the expiry edge takes priority over the timeout.
  assign timeout_hit = (state != S_IDLE) && !byte_event &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign Busy        = (state != S_IDLE);
  assign DbgState    = state;

  always_comb begin
    state_next   = state;
    cmd_tmp_next = cmd_tmp;
    arg_tmp_next = arg_tmp;
    cmd_next     = Cmd;
    arg_next     = Arg;
    valid_next   = 1'b0;
    chk_next     = 1'b0;
    to_next      = 1'b0;
    cnt_next     = cnt + CNT_W'(1);
    if (state == S_IDLE || byte_event) cnt_next = '0;
    if (byte_event) begin
      case (state)
        S_IDLE: if (RxData == HEADER) state_next = S_CMD;
        S_CMD: begin
          cmd_tmp_next = RxData;
          state_next   = S_ARG;
        end
        S_ARG: begin
          arg_tmp_next = RxData;
          state_next   = S_CHK;
        end
        S_CHK: begin
          if (RxData == (cmd_tmp ^ arg_tmp)) begin
            cmd_next   = cmd_tmp;
            arg_next   = arg_tmp;
            valid_next = 1'b1;
          end else begin
            chk_next = 1'b1;
          end
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      to_next    = 1'b1;
      state_next = S_IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= S_IDLE;
      rx_done_q  <= 1'b1;
      cnt        <= '0;
      cmd_tmp    <= '0;
      arg_tmp    <= '0;
      Cmd        <= '0;
      Arg        <= '0;
      CmdValid   <= 1'b0;
      ChkErr     <= 1'b0;
      TimeoutErr <= 1'b0;
    end else begin
      state      <= state_next;
      rx_done_q  <= RxDone;
      cnt        <= cnt_next;
      cmd_tmp    <= cmd_tmp_next;
      arg_tmp    <= arg_tmp_next;
      Cmd        <= cmd_next;
      Arg        <= arg_next;
      CmdValid   <= valid_next;
      ChkErr     <= chk_next;
      TimeoutErr <= to_next;
    end
  end

`ifdef UART_CMD_ACK_EN
  // Single-entry request slot: a new ACK/NAK overwrites a pending one; it is issued once TxBusy drops.
  logic       pend;
  logic [7:0] pend_data;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pend      <= 1'b0;
      pend_data <= '0;
      TxStart   <= 1'b0;
      TxData    <= '0;
    end else begin
      TxStart <= 1'b0;
      if (valid_next || chk_next) begin
        pend      <= 1'b1;
        pend_data <= valid_next ? 8'h06 : 8'h15;
      end else if (pend && !TxBusy) begin
        TxStart <= 1'b1;
        TxData  <= pend_data;
        pend    <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: strobe expectations are queued as frames are sent and
// popped by a monitor whenever the DUT raises CmdValid, ChkErr or TimeoutErr.
module tb_uart_cmd_parser;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] RxData;
  logic       RxDone;
  logic [7:0] Cmd, Arg;
  logic       CmdValid, ChkErr, TimeoutErr, Busy;
  logic [1:0] DbgState;
`ifdef UART_CMD_ACK_EN
  logic       TxBusy;
  logic [7:0] TxData;
  logic       TxStart;
`endif

  int vectors = 0;
  int miscompares = 0;
  // {kind, cmd, arg}; kind 1=CmdValid, 2=ChkErr, 3=TimeoutErr
  logic [17:0] exp_q[$];

  uart_cmd_parser #(.HEADER(8'hAA), .TIMEOUT_CYCLES(100), .CNT_W(18)) dut (
    .Clk(Clk), .Rst(Rst), .RxData(RxData), .RxDone(RxDone),
`ifdef UART_CMD_ACK_EN
    .TxBusy(TxBusy), .TxData(TxData), .TxStart(TxStart),
`endif
    .Cmd(Cmd), .Arg(Arg), .CmdValid(CmdValid), .ChkErr(ChkErr),
    .TimeoutErr(TimeoutErr), .Busy(Busy), .DbgState(DbgState)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor
  always @(negedge Clk) begin
    if (!Rst && (CmdValid || ChkErr || TimeoutErr)) begin
      logic [17:0] e;
      logic [1:0]  kind;
      check("strobe_onehot", 32'($countones({CmdValid, ChkErr, TimeoutErr})), 32'd1);
      kind = CmdValid ? 2'd1 : (ChkErr ? 2'd2 : 2'd3);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, kind}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {30'd0, kind}, {30'd0, e[17:16]});
        check("strobe_cmd", {24'd0, Cmd}, {24'd0, e[15:8]});
        check("strobe_arg", {24'd0, Arg}, {24'd0, e[7:0]});
      end
    end
  end

  // Called at a negedge; returns at a negedge with RxDone low for one cycle.
  task automatic send_byte(input logic [7:0] b, input int hold);
    RxData = b;
    RxDone = 1'b1;
    repeat (hold) @(negedge Clk);
    RxDone = 1'b0;
    @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send_byte(8'hAA, 3);
    send_byte(c, 3);
    send_byte(a, 3);
    send_byte(k, 3);
  endtask

  initial begin
    int  n;
    logic seen;
    Rst    = 1'b1;
    RxData = 8'hAA;
    RxDone = 1'b1;
`ifdef UART_CMD_ACK_EN
    TxBusy = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    check("reset_cmd", {24'd0, Cmd}, 32'd0);
    check("reset_arg", {24'd0, Arg}, 32'd0);
    check("reset_strobes", {29'd0, CmdValid, ChkErr, TimeoutErr}, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);

    // RxDone already high out of reset must not count as a header byte
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    check("held_level_not_byte", {31'd0, Busy}, 32'd0);
    RxDone = 1'b0;
    @(negedge Clk);

    // Valid frame
    exp_q.push_back({2'd1, 8'h12, 8'h34});
    send_frame(8'h12, 8'h34, 8'h26);
    check("busy_after_valid", {31'd0, Busy}, 32'd0);

    // Checksum error keeps previous Cmd/Arg
    exp_q.push_back({2'd2, 8'h12, 8'h34});
    send_frame(8'h12, 8'h34, 8'h27);
    check("busy_after_chkerr", {31'd0, Busy}, 32'd0);

    // Leading noise ignored
    send_byte(8'h55, 3);
    send_byte(8'h00, 3);
    check("noise_not_busy", {31'd0, Busy}, 32'd0);
    exp_q.push_back({2'd1, 8'h01, 8'h02});
    send_frame(8'h01, 8'h02, 8'h03);

    // Inter-byte timeout: strobe on the 101st negedge after the byte was driven
    send_byte(8'hAA, 3);
    exp_q.push_back({2'd3, 8'h01, 8'h02});
    RxData = 8'h12;
    RxDone = 1'b1;
    n = 0;
    seen = 1'b0;
    while (n < 300 && !seen) begin
      @(negedge Clk);
      n++;
      if (n == 3) RxDone = 1'b0;
      if (TimeoutErr) seen = 1'b1;
    end
    check("timeout_cycle", n, 32'd101);
    check("busy_after_timeout", {31'd0, Busy}, 32'd0);
    exp_q.push_back({2'd1, 8'h05, 8'h06});
    send_frame(8'h05, 8'h06, 8'h03);

    // Byte arriving on the expiry edge wins over the timeout
    send_byte(8'hAA, 3);
    RxData = 8'h12;
    RxDone = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge Clk);
      if (i == 3) RxDone = 1'b0;
    end
    RxData = 8'h34;
    RxDone = 1'b1;
    repeat (3) @(negedge Clk);
    RxDone = 1'b0;
    @(negedge Clk);
    check("byte_beats_timeout_busy", {31'd0, Busy}, 32'd1);
    exp_q.push_back({2'd1, 8'h12, 8'h34});
    send_byte(8'h26, 3);

    // Header value inside a frame is data
    exp_q.push_back({2'd1, 8'hAA, 8'h01});
    send_frame(8'hAA, 8'h01, 8'hAB);

    // Long and short RxDone levels each give one byte
    send_byte(8'hAA, 10);
    send_byte(8'h77, 1);
    send_byte(8'h88, 7);
    exp_q.push_back({2'd1, 8'h77, 8'h88});
    send_byte(8'hFF, 1);

    // Back-to-back frames with minimum spacing
    exp_q.push_back({2'd1, 8'h3C, 8'hC3});
    send_byte(8'hAA, 1); send_byte(8'h3C, 1); send_byte(8'hC3, 1); send_byte(8'hFF, 1);
    exp_q.push_back({2'd1, 8'h01, 8'h10});
    send_byte(8'hAA, 1); send_byte(8'h01, 1); send_byte(8'h10, 1); send_byte(8'h11, 1);

    // Reset mid-frame discards the partial frame and clears Cmd/Arg
    send_byte(8'hAA, 3);
    send_byte(8'h12, 3);
    send_byte(8'h34, 3);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    send_byte(8'h26, 3);
    repeat (3) @(negedge Clk);
    check("rst_mid_cmd", {24'd0, Cmd}, 32'd0);
    check("rst_mid_arg", {24'd0, Arg}, 32'd0);
    check("rst_mid_busy", {31'd0, Busy}, 32'd0);

`ifdef UART_CMD_ACK_EN
    // ACK held while the transmitter is busy
    TxBusy = 1'b1;
    exp_q.push_back({2'd1, 8'h12, 8'h34});
    send_frame(8'h12, 8'h34, 8'h26);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("ack_held", {31'd0, TxStart}, 32'd0);
    end
    TxBusy = 1'b0;
    @(negedge Clk);
    check("ack_start", {31'd0, TxStart}, 32'd1);
    check("ack_data", {24'd0, TxData}, 32'h06);
    @(negedge Clk);
    check("ack_one_cycle", {31'd0, TxStart}, 32'd0);

    // NAK after checksum error
    TxBusy = 1'b1;
    exp_q.push_back({2'd2, 8'h12, 8'h34});
    send_frame(8'h12, 8'h34, 8'h00);
    TxBusy = 1'b0;
    @(negedge Clk);
    check("nak_start", {31'd0, TxStart}, 32'd1);
    check("nak_data", {24'd0, TxData}, 32'h15);
`endif

    repeat (5) @(negedge Clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
